// File: rtl/seq_divider.sv
// seq_divider: unsigned restoring divider, one quotient bit per clock.
// Constant latency of dataSize cycles from start to the done pulse.
module seq_divider #(
    parameter int dataSize = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [dataSize-1:0] dividend,
    input  logic [dataSize-1:0] divisor,
    output logic                busy,
    output logic                done,
    output logic [dataSize-1:0] quotient,
    output logic [dataSize-1:0] remainder,
    output logic                divByZero
);

    localparam int CW = $clog2(dataSize);
    localparam logic [CW-1:0] LAST = CW'(dataSize - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic                w_accept;
    logic                w_last;
    logic [dataSize-1:0] r_dvd;
    logic [dataSize-1:0] r_dsr;
    logic [dataSize:0]   r_rem;
    logic [dataSize-1:0] r_quo;
    logic [CW-1:0]       r_cnt;
    logic [dataSize-1:0] r_quotient;
    logic [dataSize-1:0] r_remainder;
    logic                r_dbz;

    logic [dataSize:0]   w_shift;
    logic [dataSize:0]   w_diff;
    logic [dataSize:0]   w_remNext;
    logic                w_ge;
    logic [dataSize-1:0] w_quoNext;

    // One restoring step: bring in next dividend bit, trial-subtract.
    assign w_shift   = (r_rem << 1) | (dataSize+1)'(r_dvd[dataSize-1]);
    assign w_ge      = w_shift >= {1'b0, r_dsr};
    assign w_diff    = w_shift - {1'b0, r_dsr};
    assign w_remNext = w_ge ? w_diff : w_shift;
    assign w_quoNext = (r_quo << 1) | dataSize'(w_ge);

    assign quotient  = r_quotient;
    assign remainder = r_remainder;
    assign divByZero = r_dbz;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and status outputs.
    always_comb begin
        w_next   = r_state;
        busy     = 1'b0;
        done     = 1'b0;
        w_accept = 1'b0;
        w_last   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next   = RUN;
                    w_accept = 1'b1;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (r_cnt == LAST) begin
                    w_last = 1'b1;
                    w_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    w_next   = RUN;
                    w_accept = 1'b1;
                end else begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Operand capture, iteration and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dvd       <= '0;
            r_dsr       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_cnt       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else if (w_accept) begin
            r_dvd <= dividend;
            r_dsr <= divisor;
            r_rem <= '0;
            r_quo <= '0;
            r_cnt <= '0;
        end else if (r_state == RUN) begin
            r_dvd <= r_dvd << 1;
            r_rem <= w_remNext;
            r_quo <= w_quoNext;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
                r_quotient  <= w_quoNext;
                r_remainder <= w_remNext[dataSize-1:0];
                r_dbz       <= (r_dsr == '0);
            end
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and random checks of seq_divider
// against an arithmetic reference model.
module tb_seq_divider;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [N-1:0] dividend = '0;
    logic [N-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         dbz;

    int checks = 0;
    int errors = 0;

    seq_divider #(.dataSize(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .divByZero (dbz)
    );

    always #5 clk = ~clk;

    // Reference model: countdown to completion, results from / and %.
    logic         m_busy = 1'b0;
    logic         m_done = 1'b0;
    logic [N-1:0] m_q = '0;
    logic [N-1:0] m_r = '0;
    logic         m_z = 1'b0;
    logic [N-1:0] p_q = '0;
    logic [N-1:0] p_r = '0;
    logic         p_z = 1'b0;
    int           m_left = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_q    <= '0;
            m_r    <= '0;
            m_z    <= 1'b0;
            m_left <= 0;
        end else if (m_busy) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_q    <= p_q;
                m_r    <= p_r;
                m_z    <= p_z;
            end else begin
                m_done <= 1'b0;
            end
        end else begin
            m_done <= 1'b0;
            if (start) begin
                m_busy <= 1'b1;
                m_left <= N;
                if (divisor == '0) begin
                    p_q <= '1;
                    p_r <= dividend;
                    p_z <= 1'b1;
                end else begin
                    p_q <= dividend / divisor;
                    p_r <= dividend % divisor;
                    p_z <= 1'b0;
                end
            end
        end
    end

    task automatic cmp();
        checks++;
        if ({busy, done, quotient, remainder, dbz} !==
            {m_busy, m_done, m_q, m_r, m_z}) begin
            errors++;
            $display("FAIL model t=%0t got b%b d%b q%0d r%0d z%b exp b%b d%b q%0d r%0d z%b",
                     $time, busy, done, quotient, remainder, dbz,
                     m_busy, m_done, m_q, m_r, m_z);
        end
    endtask

    task automatic lit(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", nm, act, exp);
        end
    endtask

    task automatic step(input logic s, input logic [N-1:0] a,
                        input logic [N-1:0] b);
        start    = s;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        cmp();
    endtask

    task automatic idle();
        step(1'b0, N'($urandom), N'($urandom));
    endtask

    task automatic wait_done(output int k);
        k = 0;
        for (int i = 1; i <= 20; i++) begin
            idle();
            if (done === 1'b1) begin
                k = i;
                break;
            end
        end
        if (k == 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout got 0 exp 1");
        end
    endtask

    task automatic run_lit(input int a, input int b, input int eq,
                           input int er, input int ez);
        int k;
        step(1'b1, N'(a), N'(b));
        lit("busy_accept", busy, 1);
        wait_done(k);
        lit("latency", k, N);
        lit("quot", quotient, eq);
        lit("rem", remainder, er);
        lit("dbz", dbz, ez);
    endtask

    initial begin
        int nd;
        int k;
        logic s;
        logic [N-1:0] a;
        logic [N-1:0] b;

        rst = 1'b1;
        step(1'b0, '0, '0);
        step(1'b1, 8'd3, 8'd1);
        lit("rst_busy", busy, 0);
        lit("rst_done", done, 0);
        lit("rst_q", quotient, 0);
        lit("rst_r", remainder, 0);
        lit("rst_z", dbz, 0);
        rst = 1'b0;
        idle();

        run_lit(100, 7, 14, 2, 0);
        run_lit(255, 0, 255, 255, 1);
        run_lit(5, 9, 0, 5, 0);
        run_lit(200, 1, 200, 0, 0);
        run_lit(0, 0, 255, 0, 1);
        run_lit(255, 255, 1, 0, 0);
        run_lit(254, 15, 16, 14, 0);
        idle();

        // start ignored while running
        step(1'b1, 8'd100, 8'd7);
        idle();
        idle();
        step(1'b1, 8'd50, 8'd5);
        nd = 0;
        for (int i = 0; i < 15; i++) begin
            idle();
            if (done === 1'b1) begin
                nd++;
                lit("ign_q", quotient, 14);
                lit("ign_r", remainder, 2);
            end
        end
        lit("ign_ndone", nd, 1);

        // back-to-back start in the done cycle
        run_lit(100, 7, 14, 2, 0);
        step(1'b1, 8'd81, 8'd9);
        k = 0;
        for (int i = 1; i <= 20; i++) begin
            idle();
            if (done === 1'b1) begin
                k = i;
                break;
            end
            lit("hold_q", quotient, 14);
            lit("hold_r", remainder, 2);
        end
        lit("b2b_lat", k, N);
        lit("b2b_q", quotient, 9);
        lit("b2b_r", remainder, 0);

        // reset in the middle of a run
        idle();
        step(1'b1, 8'd100, 8'd7);
        idle();
        idle();
        idle();
        rst = 1'b1;
        idle();
        rst = 1'b0;
        lit("abort_busy", busy, 0);
        lit("abort_q", quotient, 0);
        lit("abort_r", remainder, 0);
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            idle();
            if (done === 1'b1) nd++;
        end
        lit("abort_ndone", nd, 0);
        run_lit(100, 7, 14, 2, 0);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            s = ($urandom_range(0, 2) == 0);
            a = N'($urandom);
            if ($urandom_range(0, 4) == 0) b = N'($urandom_range(0, 3));
            else b = N'($urandom);
            step(s, a, b);
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The block SHALL have parameter dataSize, default 8, giving the operand and result width in bits (even, >= 4).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge only.
REQ-003 The block SHALL have port rst, input, 1 bit: the reset, which is synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a division, sampled on the rising edge.
REQ-005 The block SHALL have port dividend, input, dataSize bits: unsigned numerator, sampled with start.
REQ-006 The block SHALL have port divisor, input, dataSize bits: unsigned denominator, sampled with start.
REQ-007 The block SHALL have port busy, output, 1 bit: high while a division is in progress.
REQ-008 The block SHALL have port done, output, 1 bit: single-cycle pulse marking valid results.
REQ-009 The block SHALL have port quotient, output, dataSize bits: registered unsigned quotient.
REQ-010 The block SHALL have port remainder, output, dataSize bits: registered unsigned remainder.
REQ-011 The block SHALL have port divByZero, output, 1 bit: registered flag, high when the last completed division had divisor == 0.

Function
REQ-012 The block SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-013 In IDLE or DONE, start=1 on an edge SHALL latch dividend and divisor, clear the iteration counter, enter RUN, and set busy=1 at that edge.
REQ-014 In RUN, start SHALL be ignored, and operand input changes SHALL NOT affect the result in progress.
REQ-015 RUN SHALL perform one restoring step per cycle: shift the partial remainder left, inserting the next dividend bit MSB-first; compare it with divisor; subtract if >=; shift in quotient bit 1 or 0.
REQ-016 The partial remainder and compare/subtract path SHALL be dataSize+1 bits wide, so no step overflows.
REQ-017 RUN SHALL last exactly dataSize cycles; on the edge completing the last step the block SHALL register quotient, remainder and divByZero, drive busy=0 and done=1, and enter DONE.
REQ-018 Latency SHALL be constant: done SHALL be high dataSize cycles after the edge that accepted start, independent of operand values, including divisor == 0.
REQ-019 done SHALL be high for exactly one cycle (the DONE state); the FSM SHALL then return to IDLE unless start=1 in DONE, which SHALL begin a new RUN (back-to-back, no idle cycle).
REQ-020 quotient, remainder and divByZero SHALL hold their values from done until the next completion or reset, and SHALL NOT change during a subsequent RUN.
REQ-021 For divisor == 0 the result SHALL be quotient = all ones, remainder = dividend, divByZero = 1 (the natural restoring-algorithm result).
REQ-022 For divisor != 0 the result SHALL satisfy dividend = quotient*divisor + remainder with remainder < divisor, and divByZero = 0.

Reset
REQ-023 rst=1 on an edge SHALL force IDLE and busy=0, done=0, quotient=0, remainder=0, divByZero=0, and clear all internal registers.
REQ-024 rst SHALL take priority over start, including reset in any cycle of RUN, which SHALL abort the division with no done pulse.
REQ-025 After rst deasserts, the first edge with start=1 SHALL be accepted normally.

Verification
REQ-026 dataSize=8; dividend=100, divisor=7, one-cycle start -> busy for 8 cycles, then done pulse with quotient=14, remainder=2, divByZero=0.
REQ-027 dividend=255, divisor=0 -> done after 8 cycles with quotient=255, remainder=255, divByZero=1.
REQ-028 dividend=5, divisor=9 -> quotient=0, remainder=5; and dividend=200, divisor=1 -> quotient=200, remainder=0.
REQ-029 start with 100/7; 3 cycles later start with 50/5 and change operands -> the single done reports 14/2, and no second done follows.
REQ-030 start in the DONE cycle with 81/9 after 100/7 -> second done exactly 8 cycles later with quotient=9, remainder=0; the 14/2 results hold until then.
REQ-031 rst=1 at cycle 4 of RUN -> all outputs 0 next cycle, no done pulse; a new start of 100/7 then completes correctly.
